rx: RTL and testbench



---
 rtl/tx_rx_pkg.sv | 17 +
 rtl/bit_sync.sv | 28 ++
 rtl/rx.sv | 121 ++++++++++++
 tb/tb_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tx_rx_pkg.sv
// Shared constants and state encoding for the packet link so tx and rx agree
// on framing and bit timing.
package tx_rx_pkg;

  localparam int CLK_HZ_DEF    = 65_000_000;
  localparam int BAUD_RATE_DEF = 9600;
  localparam int DIVISOR_DEF   = 6771;
  localparam int PKT_LEN_DEF   = 208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL
// so an idle-high line does not look like an edge when reset releases.
module bit_sync #(
  parameter int          WIDTH     = 1,
  parameter logic [0:0]  RESET_VAL = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_meta <= {WIDTH{RESET_VAL}};
      r_sync <= {WIDTH{RESET_VAL}};
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule

// File: rtl/rx.sv
// Serial packet receiver: start bit, PKT_LEN data bits LSB first, stop bit.
// Emits the packet with a one-cycle valid strobe, or a framing-error strobe.
module rx
  import tx_rx_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF,
  parameter int DIVISOR   = DIVISOR_DEF,
  parameter int PKT_LEN   = PKT_LEN_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               data_in,
  output logic [PKT_LEN-1:0] val_out,
  output logic               valid_out,
  output logic               frame_err_out,
  output logic               busy_out,
  output logic [1:0]         state_out
);

  localparam logic [31:0] HALF_LOAD = 32'(DIVISOR / 2 - 1);
  localparam logic [31:0] FULL_LOAD = 32'(DIVISOR - 1);
  localparam logic [7:0]  LAST_IDX  = 8'(PKT_LEN - 1);

  // Clock/baud values are descriptive; only DIVISOR drives timing.
  if (CLK_HZ <= 0 || BAUD_RATE <= 0 || DIVISOR < 4) begin : g_invalid_config
  end

  logic               w_line;
  logic               w_fall;
  logic               r_line_prev;
  rx_state_t          r_state;
  logic [31:0]        r_count;
  logic [7:0]         r_bit_idx;
  logic [PKT_LEN-1:0] r_shift;
  logic [PKT_LEN-1:0] r_val;
  logic               r_valid;
  logic               r_frame_err;

  bit_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (data_in),
    .sync_out (w_line)
  );

  assign w_fall = r_line_prev & ~w_line;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_line_prev <= 1'b1;
      r_count     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_val       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_line_prev <= w_line;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_count <= HALF_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (r_count == '0) begin
            // A line back high at mid-start-bit was a glitch, not a frame.
            if (w_line) begin
              r_state <= IDLE;
            end else begin
              r_count   <= FULL_LOAD;
              r_bit_idx <= '0;
              r_state   <= DATA;
            end
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        DATA: begin
          if (r_count == '0) begin
            r_shift <= {w_line, r_shift[PKT_LEN-1:1]};
            r_count <= FULL_LOAD;
            if (r_bit_idx == LAST_IDX) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 8'd1;
            end
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        STOP: begin
          if (r_count == '0) begin
            if (w_line) begin
              r_val   <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign val_out       = r_val;
  assign valid_out     = r_valid;
  assign frame_err_out = r_frame_err;
  assign busy_out      = (r_state != IDLE);
  assign state_out     = r_state;

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx in the small configuration (DIVISOR=16, PKT_LEN=8).
module tb_rx;

  localparam int DIV = 16;
  localparam int PL  = 8;

  logic          clk_in;
  logic          rst_in;
  logic          data_in;
  logic [PL-1:0] val_out;
  logic          valid_out;
  logic          frame_err_out;
  logic          busy_out;
  logic [1:0]    state_out;

  int n_checks;
  int n_errors;
  int cyc;
  int pin_cyc;
  int last_lat;
  int valid_cnt;
  int err_cnt;
  logic [PL-1:0] exp_q[$];

  rx #(.DIVISOR(DIV), .PKT_LEN(PL)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .val_out       (val_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .busy_out      (busy_out),
    .state_out     (state_out)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every valid pulse pops the next expected packet
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out && frame_err_out) check("valid_and_err_same_cycle", 32'd1, 32'd0);
      if (valid_out) begin
        valid_cnt++;
        last_lat = cyc - pin_cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(val_out), 32'hFFFF_FFFF);
        end else begin
          check("packet", 32'(val_out), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err_out) err_cnt++;
    end
  end

  // driver tasks; every task starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    repeat (DIV) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [PL-1:0] d, input logic stop_bit);
    pin_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < PL; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    pin_cyc   = 0;
    last_lat  = -1;
    valid_cnt = 0;
    err_cnt   = 0;
    rst_in    = 1'b1;
    data_in   = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_val", 32'(val_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_err", 32'(frame_err_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    rst_in = 1'b0;
    idle(10);

    // single frame 0x3C with latency from the pin edge
    exp_q.push_back(8'h3C);
    last_lat = -1;
    send_frame(8'h3C, 1'b1);
    idle(4);
    check("lat_3c_in_window", 32'((last_lat >= DIV/2 + (PL+1)*DIV + 3) &&
                                   (last_lat <= DIV/2 + (PL+1)*DIV + 4)), 32'd1);
    check("val_3c", 32'(val_out), 32'h3C);
    check("cnt_after_3c", 32'(valid_cnt), 32'd1);
    check("busy_idle_3c", 32'(busy_out), 32'd0);

    // glitch: 5 cycles low then high
    data_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    check("glitch_busy_high", 32'(busy_out), 32'd1);
    idle(7);
    check("glitch_busy_low", 32'(busy_out), 32'd0);
    idle(20);
    check("glitch_no_valid", 32'(valid_cnt), 32'd1);
    check("glitch_no_err", 32'(err_cnt), 32'd0);

    // framing error, then a held-low break
    send_frame(8'hFF, 1'b0);
    data_in = 1'b0;
    repeat (100) @(posedge clk_in);
    #1;
    check("ferr_pulses", 32'(err_cnt), 32'd1);
    check("ferr_val_kept", 32'(val_out), 32'h3C);
    check("ferr_no_valid", 32'(valid_cnt), 32'd1);
    check("break_not_busy", 32'(busy_out), 32'd0);
    idle(20);

    // back-to-back with a single stop bit
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    idle(4);
    check("b2b_count", 32'(valid_cnt), 32'd3);
    check("b2b_last_val", 32'(val_out), 32'h80);
    check("b2b_no_err", 32'(err_cnt), 32'd1);

    // reset during data bit 4
    data_in = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    data_in = 1'b1;
    repeat (DIV/2) @(posedge clk_in);
    #1;
    check("pre_rst_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_val", 32'(val_out), 32'd0);
    check("mid_rst_busy", 32'(busy_out), 32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(20);
    check("post_rst_no_valid", 32'(valid_cnt), 32'd3);

    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    check("val_5a", 32'(val_out), 32'h5A);
    check("cnt_after_5a", 32'(valid_cnt), 32'd4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
